// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch unit.
//   fetch_state_e : fetch FSM states (REQ issue, WAIT for response, HOLD for decode)
//   INSTR_BYTES   : byte size of one instruction, the sequential PC step
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/if_out_reg.sv
// if_out_reg: output buffer between the fetch FSM and decode.
// Holds one fetched instruction together with its PC.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture instr_in / pc_in and mark the buffer valid
//   flush     : drop the buffered instruction (redirect); wins over load/accept
//   accept    : decode is ready; clears a valid buffer
//   instr_in  : instruction word from memory
//   pc_in     : PC the instruction was fetched from
//   if_valid  : buffer holds an instruction (forced low while rst is high)
//   if_instr  : buffered instruction
//   if_pc     : PC of the buffered instruction
module if_out_reg #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            accept,
    input  logic [ILEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            if_valid,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    logic valid_q;

    // Flush takes priority so that a redirect in the same cycle as an
    // accept or a capture never leaves a stale instruction visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
        end else if (load) begin
            valid_q  <= 1'b1;
            if_instr <= instr_in;
            if_pc    <= pc_in;
        end else if (accept) begin
            valid_q  <= 1'b0;
        end
    end

    // Gated so decode sees nothing valid during the reset cycle itself.
    assign if_valid = valid_q & ~rst;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues one fetch at a time to
// instruction memory and hands {pc, instr} to decode.
//   clk, rst        : clock, synchronous active-high reset
//   redirect_valid  : taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc     : redirect target (low two bits ignored)
//   imem_req        : fetch request, address on imem_addr
//   imem_addr       : fetch address, always equal to fetch_pc
//   imem_gnt        : memory accepted the request this cycle
//   imem_rvalid     : in-order response valid, carries imem_rdata
//   imem_rdata      : response instruction word
//   if_valid        : instruction available to decode
//   if_instr, if_pc : buffered instruction and its PC
//   if_ready        : decode accepts when if_valid is high
//   fetch_pc        : current fetch PC
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready,
    output logic [XLEN-1:0] fetch_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] redirect_target;
    logic            drop, drop_nxt;
    logic            load;

    assign redirect_target = redirect_pc & ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC_ALIGNED;
            drop     <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= pc_nxt;
            drop     <= drop_nxt;
        end
    end

    // drop marks an outstanding response that belongs to the old path and
    // must be swallowed when it returns. Redirect overrides everything else.
    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        drop_nxt  = drop;
        load      = 1'b0;
        unique case (state)
            REQ: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_target;
                    if (imem_gnt) begin
                        drop_nxt  = 1'b1;
                        state_nxt = WAIT;
                    end
                end else if (imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    drop_nxt  = 1'b0;
                    state_nxt = REQ;
                    if (redirect_valid) begin
                        pc_nxt = redirect_target;
                    end else if (!drop) begin
                        load      = 1'b1;
                        pc_nxt    = fetch_pc + XLEN'(INSTR_BYTES);
                        state_nxt = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_nxt   = redirect_target;
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_target;
                    state_nxt = REQ;
                end else if (if_ready) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase
    end

    assign imem_req  = (state == REQ) & ~rst;
    assign imem_addr = fetch_pc;

    if_out_reg #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .flush    (redirect_valid),
        .accept   (if_ready),
        .instr_in (imem_rdata),
        .pc_in    (fetch_pc),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus a randomized run. A memory
// model answers fetches with a fixed word per address, and a program-order
// scoreboard checks every instruction decode accepts against the expected
// PC stream (sequential +4, retargeted by redirect and reset).
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic [31:0] fetch_pc;

    int n_checks = 0;
    int n_errors = 0;

    // memory model state and knobs
    bit          pend_valid = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    int          pend_delay = 0;
    int          req_age = 0;
    int          gnt_delay = 0;
    int          rv_delay = 0;
    bit          rand_mem = 1'b0;
    bit          stray_rv = 1'b0;
    bit          override_en = 1'b0;
    logic [31:0] override_data = '0;

    // scoreboard state
    logic [31:0] exp_pc = RESET_PC;
    int          n_xfer = 0;
    int          cyc = 0;
    bit          prev_req = 1'b0;
    bit          prev_gnt = 1'b0;
    bit          prev_redirect = 1'b0;
    bit          prev_rst = 1'b1;
    logic [31:0] prev_addr = '0;

    logic [31:0] addrs[$];
    int          req_cycles[$];
    int          val_cycles[$];
    logic [31:0] first_instr;
    logic [31:0] first_pc;
    bit          seen;
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    int          start_xfer;
    logic        r_rdy;
    logic        r_redir;
    logic        r_rst;
    logic [31:0] r_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN     (32),
        .ILEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .fetch_pc       (fetch_pc)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     tag, actual, expected, cyc);
        end
    endtask

    // One outstanding fetch; response comes pend_delay cycles after the grant
    // cycle plus one. Memory forgets everything while rst is high.
    task automatic driveMemory();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (rst) begin
            pend_valid = 1'b0;
            req_age    = 0;
            return;
        end
        if (stray_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBADB_AD00;
        end else if (pend_valid && pend_cnt >= pend_delay) begin
            imem_rvalid = 1'b1;
            imem_rdata  = override_en ? override_data : memWord(pend_addr);
            override_en = 1'b0;
            pend_valid  = 1'b0;
        end else if (pend_valid) begin
            pend_cnt++;
        end
        if (imem_req && !pend_valid) begin
            if (req_age >= gnt_delay) begin
                imem_gnt   = 1'b1;
                pend_valid = 1'b1;
                pend_addr  = imem_addr;
                pend_cnt   = 0;
                pend_delay = rand_mem ? int'($urandom_range(0, 2)) : rv_delay;
                req_age    = 0;
                if (rand_mem) gnt_delay = int'($urandom_range(0, 3));
            end else begin
                req_age++;
            end
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, answer memory,
    // and score the transfer that the next rising edge will perform.
    task automatic applyStimulus(input logic rdy, input logic redir,
                                 input logic [31:0] rpc, input logic rs);
        @(negedge clk);
        if_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rst            = rs;
        #1;
        driveMemory();
        if (prev_redirect && !rs)
            checkOutput("flush_after_redirect", {31'b0, if_valid}, 32'd0);
        if (!rs && !prev_rst && imem_req && prev_req && !prev_gnt && !prev_redirect)
            checkOutput("addr_stable", imem_addr, prev_addr);
        if (!rs && imem_req)
            checkOutput("addr_align", imem_addr & 32'h3, 32'd0);
        if (!rs && if_valid && rdy && !redir) begin
            checkOutput("xfer_pc", if_pc, exp_pc);
            checkOutput("xfer_instr", if_instr, memWord(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_xfer++;
        end
        if (redir) exp_pc = rpc & ~32'h3;
        if (rs) exp_pc = RESET_PC;
        prev_req      = imem_req;
        prev_gnt      = imem_gnt;
        prev_redirect = redir;
        prev_rst      = rs;
        prev_addr     = imem_addr;
        cyc++;
    endtask

    task automatic doReset();
        gnt_delay   = 0;
        rv_delay    = 0;
        req_age     = 0;
        stray_rv    = 1'b0;
        override_en = 1'b0;
        rand_mem    = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    // Runs up to n cycles with decode ready and records the first instruction seen.
    task automatic runUntilValid(input int n);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            if (if_valid && !seen) begin
                seen        = 1'b1;
                first_pc    = if_pc;
                first_instr = if_instr;
            end
        end
    endtask

    initial begin
        // reset state
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("rst_fetch_pc", fetch_pc, RESET_PC);
        checkOutput("rst_if_instr", if_instr, 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'd0);

        // zero-wait memory, decode always ready
        doReset();
        addrs.delete();
        req_cycles.delete();
        val_cycles.delete();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            if (imem_req) begin
                addrs.push_back(imem_addr);
                req_cycles.push_back(cyc);
            end
            if (if_valid) begin
                val_cycles.push_back(cyc);
                if (!seen) first_instr = if_instr;
                seen = 1'b1;
            end
        end
        checkOutput("t1_nreq", addrs.size(), 32'd4);
        checkOutput("t1_nvalid", val_cycles.size(), 32'd3);
        if (addrs.size() >= 3) begin
            checkOutput("t1_addr0", addrs[0], 32'h0);
            checkOutput("t1_addr1", addrs[1], 32'h4);
            checkOutput("t1_addr2", addrs[2], 32'h8);
        end
        if (val_cycles.size() >= 2 && req_cycles.size() >= 1) begin
            checkOutput("t1_latency", val_cycles[0] - req_cycles[0], 32'd2);
            checkOutput("t1_spacing", val_cycles[1] - val_cycles[0], 32'd3);
            checkOutput("t1_first_instr", first_instr, 32'h0000_0013);
        end

        // delayed grant, then a long HOLD, then redirect out of HOLD
        doReset();
        gnt_delay = 100;
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b0);
        req_age   = 0;
        gnt_delay = 3;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("t2_req_held", {31'b0, imem_req}, 32'd1);
            checkOutput("t2_addr_held", imem_addr, 32'h10);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t2_wait_no_req", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("t4_hold_valid", {31'b0, if_valid}, 32'd1);
            checkOutput("t4_hold_pc", if_pc, 32'h10);
            checkOutput("t4_hold_instr", if_instr, memWord(32'h10));
            checkOutput("t4_hold_no_req", {31'b0, imem_req}, 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 32'h203, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_redirect_pc", fetch_pc, 32'h200);
        checkOutput("t4_flushed", {31'b0, if_valid}, 32'd0);
        checkOutput("t4_refetch_addr", imem_addr, 32'h200);

        // redirect while waiting; the stale response must vanish
        doReset();
        gnt_delay     = 0;
        rv_delay      = 2;
        override_en   = 1'b1;
        override_data = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
        checkOutput("t3_valid_c1", {31'b0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_valid_c2", {31'b0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_stale_rvalid", {31'b0, imem_rvalid}, 32'd1);
        rv_delay = 0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_valid_c4", {31'b0, if_valid}, 32'd0);
        checkOutput("t3_new_req", {31'b0, imem_req}, 32'd1);
        checkOutput("t3_new_addr", imem_addr, 32'h100);
        runUntilValid(6);
        checkOutput("t3_got_instr", {31'b0, seen}, 32'd1);
        if (seen) begin
            checkOutput("t3_first_pc", first_pc, 32'h100);
            checkOutput("t3_first_instr", first_instr, memWord(32'h100));
        end

        // PC wrap at the top of the address space
        doReset();
        gnt_delay = 100;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        req_age   = 0;
        gnt_delay = 0;
        addrs.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            if (imem_req) addrs.push_back(imem_addr);
        end
        checkOutput("t5_nreq", addrs.size(), 32'd3);
        if (addrs.size() >= 2) begin
            checkOutput("t5_addr_top", addrs[0], 32'hFFFF_FFFC);
            checkOutput("t5_addr_wrap", addrs[1], 32'h0);
        end

        // reset in WAIT, then a stray response after release
        doReset();
        gnt_delay = 0;
        rv_delay  = 5;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t6_rst_no_req", {31'b0, imem_req}, 32'd0);
        gnt_delay = 100;
        stray_rv  = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        stray_rv  = 1'b0;
        checkOutput("t6_fetch_pc", fetch_pc, RESET_PC);
        checkOutput("t6_req", {31'b0, imem_req}, 32'd1);
        checkOutput("t6_addr", imem_addr, RESET_PC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_stray_ignored_req", {31'b0, imem_req}, 32'd1);
        checkOutput("t6_stray_ignored_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("t6_stray_ignored_pc", fetch_pc, RESET_PC);
        req_age   = 0;
        gnt_delay = 0;
        rv_delay  = 0;
        runUntilValid(6);
        checkOutput("t6_got_instr", {31'b0, seen}, 32'd1);
        if (seen) begin
            checkOutput("t6_first_pc", first_pc, RESET_PC);
            checkOutput("t6_first_instr", first_instr, memWord(RESET_PC));
        end

        // randomized traffic against the program-order scoreboard
        doReset();
        rand_mem   = 1'b1;
        gnt_delay  = int'($urandom_range(0, 3));
        start_xfer = n_xfer;
        for (int i = 0; i < 3000; i++) begin
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_redir = ($urandom_range(0, 19) == 0);
            r_rst   = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 7) == 0)
                r_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else
                r_pc = $urandom & 32'h0000_FFFF;
            applyStimulus(r_rdy, r_redir, r_pc, r_rst);
        end
        checkOutput("rand_progress", {31'b0, (n_xfer - start_xfer) >= 100}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
